gbuf_b_reader: RTL and testbench

Read-side sequencer for the B-operand global buffer banks. It accepts a burst command, then streams `len` consecutive words from one selected bank using the banks' negedge-registered read port. It splits each word into int8 lanes and presents them diagonally skewed to the systolic-array column inputs, with per-lane valid, array back-pressure, drain and a done pulse.

---
 rtl/gbuf_b_reader.sv | 148 ++++++++++++++
 tb/tb_gbuf_b_reader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gbuf_b_reader.sv
// Read-side burst sequencer for the B-operand global buffer: streams len words from one bank
// and presents them as int8 lanes to the array columns. Define GBUF_B_SKEW_EN for diagonal lane skew.
module gbuf_b_reader #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_BITS-1:0]   base_addr,
    input  logic [ADDR_BITS-1:0]   len,
    input  logic [2:0]             bank_sel,
    input  logic                   stall,
    input  logic [DATA_BITS-1:0]   rd_data,
    output logic [ADDR_BITS-1:0]   index_out,
    output logic [2:0]             buf_idx_out,
    output logic                   rd_out,
    output logic [DATA_BITS-1:0]   b_out,
    output logic [DATA_BITS/8-1:0] b_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int LANES = DATA_BITS / 8;
`ifdef GBUF_B_SKEW_EN
    localparam int DRAIN_CYCLES = LANES;
`else
    localparam int DRAIN_CYCLES = 1;
`endif
    localparam int DRW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                 state_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [ADDR_BITS-1:0]   remain_q;
    logic [2:0]             bank_q;
    logic [DRW-1:0]         drain_q;
    logic                   zero_len_q;
    logic                   done_q;
    logic                   issued;
    logic                   advance;

    // The bank registers data_out on the negedge of the issuing cycle, so the word is
    // on rd_data by the following posedge; the issue strobe itself is the valid flag.
    assign issued  = (state_q == READ) && !stall;
    assign advance = !(stall && busy);

    assign rd_out      = issued;
    assign index_out   = addr_q;
    assign buf_idx_out = bank_q;
    assign busy        = (state_q == READ) || (state_q == DRAIN);
    assign done        = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            bank_q     <= '0;
            drain_q    <= '0;
            zero_len_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q   <= base_addr;
                        remain_q <= len;
                        bank_q   <= bank_sel;
                        if (len == '0) begin
                            state_q    <= DONE;
                            zero_len_q <= 1'b1;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    if (!stall) begin
                        addr_q   <= addr_q + 1'b1;
                        remain_q <= remain_q - 1'b1;
                        if (remain_q == ADDR_BITS'(1)) begin
                            state_q <= DRAIN;
                            drain_q <= DRW'(DRAIN_CYCLES - 1);
                        end
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        if (drain_q == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            drain_q <= drain_q - 1'b1;
                        end
                    end
                end
                default: begin
                    // An empty burst spends one cycle here silently so done lands a cycle later.
                    state_q    <= IDLE;
                    done_q     <= zero_len_q;
                    zero_len_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef GBUF_B_SKEW_EN
        localparam int DEPTH = gi + 1;
`else
        localparam int DEPTH = 1;
`endif
        logic [7:0]         lane_byte;
        logic [8*DEPTH-1:0] dat_q;
        logic [DEPTH-1:0]   vld_q;

        assign lane_byte = issued ? rd_data[8*gi +: 8] : 8'h00;

        if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dat_q <= '0;
                    vld_q <= '0;
                end else if (advance) begin
                    dat_q <= lane_byte;
                    vld_q <= issued;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dat_q <= '0;
                    vld_q <= '0;
                end else if (advance) begin
                    dat_q <= {dat_q[8*DEPTH-9:0], lane_byte};
                    vld_q <= {vld_q[DEPTH-2:0], issued};
                end
            end
        end

        assign b_out[8*gi +: 8] = dat_q[8*DEPTH-1 -: 8];
        assign b_valid[gi]      = vld_q[DEPTH-1];
    end

endmodule

// File: tb/tb_gbuf_b_reader.sv
// Scoreboard bench for gbuf_b_reader: directed bursts push per-cycle expected outputs,
// a negedge monitor pops and compares whenever the DUT shows activity.
module tb_gbuf_b_reader;

    localparam int LANES = 4;
`ifdef GBUF_B_SKEW_EN
    localparam int D    = LANES;
    localparam bit SKEW = 1'b1;
`else
    localparam int D    = 1;
    localparam bit SKEW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] len;
    logic [2:0]  bank_sel;
    logic        stall;
    logic [31:0] rd_data = 32'h0;
    logic [15:0] index_out;
    logic [2:0]  buf_idx_out;
    logic        rd_out;
    logic [31:0] b_out;
    logic [3:0]  b_valid;
    logic        busy;
    logic        done;

    gbuf_b_reader #(.ADDR_BITS(16), .DATA_BITS(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .bank_sel(bank_sel), .stall(stall), .rd_data(rd_data), .index_out(index_out),
        .buf_idx_out(buf_idx_out), .rd_out(rd_out), .b_out(b_out), .b_valid(b_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        rd;
        logic        chk_idx;
        logic [15:0] idx;
        logic [2:0]  bank;
        logic [31:0] b;
        logic [3:0]  v;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t        sbq[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [31:0] mem [int];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word_at(logic [2:0] b, logic [15:0] a);
        int key;
        key = {13'h0, b, a};
        if (mem.exists(key)) return mem[key];
        return {13'h0, b, a} ^ 32'h5A5A_0000;
    endfunction

    // Bank model: registered read on negedge, holds data_out while the strobe is low.
    always @(negedge clk) if (rd_out) rd_data <= word_at(buf_idx_out, index_out);

    exp_t mon_e;
    logic mon_ok;
    always @(negedge clk) begin
        if (rst_n) begin
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                mon_e = sbq.pop_front();
                tests++;
                fails++;
                $display("FAIL missing_event: cycle %0d passed without its output (required done=%b b_out=%h)",
                         mon_e.cyc, mon_e.done, mon_e.b);
            end
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                mon_e  = sbq.pop_front();
                tests++;
                mon_ok = (rd_out === mon_e.rd) && (busy === mon_e.busy) && (done === mon_e.done) &&
                         (b_out === mon_e.b) && (b_valid === mon_e.v) &&
                         (!mon_e.chk_idx || (index_out === mon_e.idx && buf_idx_out === mon_e.bank));
                if (!mon_ok) begin
                    fails++;
                    $display("FAIL cycle_%0d: got rd=%b idx=%h bank=%0d b=%h v=%b busy=%b done=%b, required rd=%b idx=%h bank=%0d b=%h v=%b busy=%b done=%b",
                             cyc, rd_out, index_out, buf_idx_out, b_out, b_valid, busy, done,
                             mon_e.rd, mon_e.idx, mon_e.bank, mon_e.b, mon_e.v, mon_e.busy, mon_e.done);
                end else begin
                    $display("[TB] cyc %0d rd=%b idx=%h b=%h v=%b busy=%b done=%b ok",
                             cyc, rd_out, index_out, b_out, b_valid, busy, done);
                end
            end else if (busy || done || rd_out || b_valid != 4'h0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: cycle %0d got rd=%b b=%h v=%b busy=%b done=%b, required no activity",
                         cyc, rd_out, b_out, b_valid, busy, done);
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end else begin
            $display("[TB] %s = %h ok", name, act);
        end
    endtask

    task automatic chk_all_zero();
        chk("rst_index_out", 32'(index_out), 32'h0);
        chk("rst_buf_idx_out", 32'(buf_idx_out), 32'h0);
        chk("rst_rd_out", 32'(rd_out), 32'h0);
        chk("rst_b_out", b_out, 32'h0);
        chk("rst_b_valid", 32'(b_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
    endtask

    // Expected timeline: word k lane i appears at unstalled time 1+k+i (1+k without skew),
    // done at len+D (1 for empty bursts); a stalled cycle repeats the current time with rd_out=0.
    task automatic push_burst(logic [15:0] base, logic [15:0] l, logic [2:0] bank,
                              logic [31:0] stall_mask, int max_n, int c0);
        int   u;
        int   done_u;
        int   k;
        bit   st;
        exp_t e;
        logic [31:0] w;
        u      = 0;
        done_u = (l == 16'h0) ? 1 : int'(l) + D;
        for (int n = 0; n < max_n && n < 64; n++) begin
            e.cyc     = c0 + n;
            e.busy    = (l != 16'h0) && (u < done_u);
            e.done    = (u == done_u);
            st        = stall_mask[n] && e.busy;
            e.chk_idx = (u < int'(l));
            e.rd      = (u < int'(l)) && !st;
            e.idx     = base + 16'(u);
            e.bank    = bank;
            e.b       = 32'h0;
            e.v       = 4'h0;
            for (int i = 0; i < LANES; i++) begin
                k = SKEW ? (u - 1 - i) : (u - 1);
                if (k >= 0 && k < int'(l)) begin
                    w              = word_at(bank, base + 16'(k));
                    e.v[i]         = 1'b1;
                    e.b[8*i +: 8]  = w[8*i +: 8];
                end
            end
            if (e.busy || e.done || e.rd || e.v != 4'h0) sbq.push_back(e);
            if (e.done) break;
            if (!st) u++;
        end
    endtask

    task automatic run(logic [15:0] base, logic [15:0] l, logic [2:0] bank,
                       logic [31:0] stall_mask, int max_n, bit extra_start);
        int c0;
        int ncyc;
        @(posedge clk); #1;
        base_addr = base;
        len       = l;
        bank_sel  = bank;
        start     = 1'b1;
        @(posedge clk); #1;
        c0    = cyc;
        start = 1'b0;
        push_burst(base, l, bank, stall_mask, max_n, c0);
        ncyc = int'(l) + D + $countones(stall_mask) + 6;
        if (max_n < ncyc) ncyc = max_n;
        for (int n = 0; n < ncyc; n++) begin
            stall = stall_mask[n];
            if (extra_start && n == 1) begin
                start     = 1'b1;
                base_addr = 16'h1234;
                len       = 16'h3;
                bank_sel  = 3'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        stall = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        mem[{13'h0, 3'd2, 16'h0010}] = 32'h4433_2211;
        mem[{13'h0, 3'd2, 16'h0011}] = 32'h8877_6655;
        mem[{13'h0, 3'd0, 16'h0010}] = 32'hBAD0_BAD0;
        mem[{13'h0, 3'd3, 16'hFFFF}] = 32'hCAFE_F00D;
        mem[{13'h0, 3'd3, 16'h0000}] = 32'h0102_0304;
        mem[{13'h0, 3'd2, 16'h0020}] = 32'hDEAD_BEEF;

        rst_n = 1'b0; start = 1'b0; stall = 1'b0;
        base_addr = 16'h0; len = 16'h0; bank_sel = 3'd0;
        #13;
        chk_all_zero();
        @(posedge clk); #1;
        rst_n = 1'b1;

        run(16'h0010, 16'd2, 3'd2, 32'h0, 64, 1'b0);          // basic burst
        run(16'h0010, 16'd2, 3'd2, 32'h2, 64, 1'b0);          // stall in cycle 1
        run(16'h0040, 16'd0, 3'd5, 32'h0, 64, 1'b0);          // empty burst
        run(16'hFFFF, 16'd2, 3'd3, 32'h0, 64, 1'b1);          // wrap + ignored start
        run(16'h0010, 16'd2, 3'd2, 32'h18, 64, 1'b0);         // stalls during drain

        run(16'h0010, 16'd2, 3'd2, 32'h0, 2, 1'b0);           // reset lands in cycle 2
        rst_n = 1'b0;
        #1;
        chk_all_zero();
        @(posedge clk); #1;
        rst_n = 1'b1;
        run(16'h0020, 16'd1, 3'd2, 32'h0, 64, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL leftover_event: cycle %0d never checked", sbq[0].cyc);
            void'(sbq.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
